// File: rtl/io_bus_pkg.sv
// Shared types and constants for the peripheral I/O bus initiator.
package io_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Strobe encodings on the bus RW pair (bit1 = read, bit0 = write)
  localparam logic [1:0] RW_IDLE = 2'b00;
  localparam logic [1:0] RW_WR   = 2'b01;
  localparam logic [1:0] RW_RD   = 2'b10;

  // port[15:7] of the 0x380-0x3FF window
  localparam logic [8:0] WIN_BASE_DEF = 9'h007;

  // Returned for read bytes that got no answer (skipped or timed out)
  localparam logic [7:0] MISS_FILL = 8'hFF;

endpackage

// File: rtl/io_bus_master.sv
// Initiator end of the 8-bit peripheral I/O bus: decodes the port window,
// splits word accesses into two byte cycles and times out silent responders.
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [8:0]  WIN_BASE = WIN_BASE_DEF
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic        iReq,
  input  logic        iWr,
  input  logic        iWord,
  input  logic [15:0] iPort,
  input  logic [15:0] iWrData,
  output logic        oBusy,
  output logic        oDone,
  output logic [15:0] oRdData,
  output logic        oTimeout,
  output logic [1:0]  oBusRW,
  output logic [6:0]  oBusAdr,
  output logic [7:0]  oBusData,
  input  logic [7:0]  iBusData,
  input  logic        iBusAck
);

  state_e      state_q, state_d;
  logic        wr_q, wr_d, word_q, word_d, idx_q, idx_d;
  logic [15:0] port_q, port_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d, bdata_q, bdata_d;
  logic        tmo_q, tmo_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]  rw_q, rw_d;
  logic [6:0]  adr_q, adr_d;
  logic        dec;

  // State register
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus next values of every registered output; the strobe is
  // computed on entry to ISSUE so it is high exactly while ISSUE is current.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    word_d  = word_q;
    port_d  = port_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    adr_d   = adr_q;
    bdata_d = bdata_q;
    rw_d    = RW_IDLE;
    dec     = 1'b0;
    case (state_q)
      ST_IDLE: if (iReq) begin
        wr_d    = iWr;
        word_d  = iWord;
        port_d  = iPort;
        wdata_d = iWrData;
        idx_d   = 1'b0;
        rdata_d = '0;
        tmo_d   = 1'b0;
        dec     = 1'b1;
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (iBusAck) begin
          // ack beats a simultaneous expiry
          if (!wr_q) begin
            if (idx_q) rdata_d[15:8] = iBusData;
            else       rdata_d[7:0]  = iBusData;
          end
          state_d = ST_NEXT;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(TIMEOUT)) begin
            if (!wr_q) begin
              if (idx_q) rdata_d[15:8] = MISS_FILL;
              else       rdata_d[7:0]  = MISS_FILL;
            end
            tmo_d   = 1'b1;
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (word_q && !idx_q) begin
          idx_d  = 1'b1;
          port_d = port_q + 16'd1;
          dec    = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Window decode of the byte about to be handled
    if (dec) begin
      if (port_d[15:7] == WIN_BASE) begin
        state_d = ST_ISSUE;
        rw_d    = wr_d ? RW_WR : RW_RD;
        adr_d   = port_d[6:0];
        bdata_d = !wr_d ? 8'h00 : (idx_d ? wdata_d[15:8] : wdata_d[7:0]);
      end else begin
        state_d = ST_NEXT;
        if (!wr_d) begin
          if (idx_d) rdata_d[15:8] = MISS_FILL;
          else       rdata_d[7:0]  = MISS_FILL;
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      wr_q    <= 1'b0;
      word_q  <= 1'b0;
      idx_q   <= 1'b0;
      port_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rw_q    <= RW_IDLE;
      adr_q   <= '0;
      bdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      port_q  <= port_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rw_q    <= rw_d;
      adr_q   <= adr_d;
      bdata_q <= bdata_d;
    end
  end

  assign oBusy    = busy_q;
  assign oDone    = done_q;
  assign oRdData  = rdata_q;
  assign oTimeout = tmo_q;
  assign oBusRW   = rw_q;
  assign oBusAdr  = adr_q;
  assign oBusData = bdata_q;

endmodule
